// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words, writes them to imem
// from address 0 and holds the core in reset until the whole program has landed.
module imem_boot_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_WORDS  = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_in_valid,
    input  logic [7:0]            i_in_data,
    output logic                  o_in_ready,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [31:0]           o_imem_wdata,
    output logic                  o_core_reset,
    output logic                  o_done,
    output logic                  o_error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_len;
    logic [1:0]            r_byte_cnt;
    logic [15:0]           r_word_cnt;
    logic [23:0]           r_shift;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_done;
    logic                  r_core_reset;

    logic                  w_accept;
    logic [15:0]           w_len_full;
    logic                  w_len_bad;
    logic                  w_last;
    logic                  w_run_hold;

    assign o_in_ready   = (r_state == LEN0) || (r_state == LEN1) || (r_state == DATA);
    assign o_imem_we    = (r_state == WRITE);
    assign o_error      = (r_state == ERR);
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_done       = r_done;
    assign o_core_reset = r_core_reset;

    assign w_accept   = o_in_ready && i_in_valid;
    assign w_len_full = {i_in_data, r_len[7:0]};
    assign w_len_bad  = (w_len_full == 16'd0) || (32'(w_len_full) > MAX_WORDS);
    assign w_last     = (r_word_cnt == r_len - 16'd1);
    // DONE with no restart request: core keeps running through the next cycle.
    assign w_run_hold = (r_state == DONE) && !i_start;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:  w_state_nxt = LEN0;
            LEN0:  if (w_accept) w_state_nxt = LEN1;
            LEN1:  if (w_accept) w_state_nxt = w_len_bad ? ERR : DATA;
            DATA:  if (w_accept && (r_byte_cnt == 2'd3)) w_state_nxt = WRITE;
            WRITE: w_state_nxt = w_last ? DONE : DATA;
            DONE:  if (i_start) w_state_nxt = LEN0;
            ERR:   if (i_start) w_state_nxt = LEN0;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_len        <= '0;
            r_byte_cnt   <= '0;
            r_word_cnt   <= '0;
            r_shift      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_done       <= 1'b0;
            r_core_reset <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_done       <= w_run_hold;
            r_core_reset <= !w_run_hold;
            if (w_accept) begin
                unique case (r_state)
                    LEN0: r_len[7:0] <= i_in_data;
                    LEN1: begin
                        r_len[15:8] <= i_in_data;
                        r_byte_cnt  <= '0;
                        r_word_cnt  <= '0;
                    end
                    DATA: begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        unique case (r_byte_cnt)
                            2'd0: r_shift[7:0]   <= i_in_data;
                            2'd1: r_shift[15:8]  <= i_in_data;
                            2'd2: r_shift[23:16] <= i_in_data;
                            2'd3: begin
                                r_wdata <= {i_in_data, r_shift};
                                r_addr  <= r_word_cnt[ADDR_WIDTH-1:0];
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
            if ((r_state == WRITE) && !w_last) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader against a stream-level reference model.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    int          n_checks = 0;
    int          n_fail = 0;
    int          we_count = 0;
    logic [7:0]  stream[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] imem_model[256];

    imem_boot_loader #(
        .ADDR_WIDTH(8),
        .MAX_WORDS (256)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_imem_we   (imem_we),
        .o_imem_addr (imem_addr),
        .o_imem_wdata(imem_wdata),
        .o_core_reset(core_reset),
        .o_done      (done),
        .o_error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write monitor: every strobe must match the next word the model predicts.
    always @(negedge clk) begin
        if (imem_we) begin
            we_count++;
            imem_model[imem_addr] = imem_wdata;
            check("ready_low_in_write", {31'd0, in_ready}, 32'd0);
            if (exp_addr.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                check("write_addr", {24'd0, imem_addr}, 32'(exp_addr.pop_front()));
                check("write_data", imem_wdata, exp_data.pop_front());
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns at 1ns after the edge on which the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int stall_pct);
        bit acc = 1'b0;
        int cyc = 0;
        bit stall;
        while (!acc && cyc < 200) begin
            @(negedge clk);
            stall    = ($urandom_range(0, 99) < stall_pct);
            in_valid = !stall;
            in_data  = stall ? 8'($urandom) : b;
            acc      = !stall && in_ready;
            cyc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("byte_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_we"}, {31'd0, imem_we}, 32'd0);
        check({tag, "_addr"}, {24'd0, imem_addr}, 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    // Predicts the writes from the stream alone, sends it, then checks the ending.
    task automatic run_load(input int stall_pct);
        int n;
        bit bad;
        int base;
        n    = int'({stream[1], stream[0]});
        bad  = (n == 0) || (n > 256);
        base = we_count;
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(i);
                exp_data.push_back({stream[2+4*i+3], stream[2+4*i+2],
                                    stream[2+4*i+1], stream[2+4*i]});
            end
        end
        for (int i = 0; i < stream.size(); i++) send_byte(stream[i], stall_pct);
        if (bad) begin
            @(posedge clk);
            #1;
            check("err_flag", {31'd0, error}, 32'd1);
            check("err_core_reset", {31'd0, core_reset}, 32'd1);
            check("err_ready", {31'd0, in_ready}, 32'd0);
            repeat (3) @(posedge clk);
            #1;
            check("err_no_writes", 32'(we_count - base), 32'd0);
            check("err_done", {31'd0, done}, 32'd0);
        end else begin
            check("last_we", {31'd0, imem_we}, 32'd1);
            check("last_done_t", {31'd0, done}, 32'd0);
            @(posedge clk);
            #1;
            check("done_t1", {31'd0, done}, 32'd0);
            check("core_reset_t1", {31'd0, core_reset}, 32'd1);
            @(posedge clk);
            #1;
            check("done_t2", {31'd0, done}, 32'd1);
            check("core_reset_t2", {31'd0, core_reset}, 32'd0);
            check("done_ready", {31'd0, in_ready}, 32'd0);
            check("write_count", 32'(we_count - base), 32'(n));
            check("pending_writes", 32'(exp_addr.size()), 32'd0);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_core_reset", {31'd0, core_reset}, 32'd1);
        check("start_done", {31'd0, done}, 32'd0);
        check("start_error", {31'd0, error}, 32'd0);
        check("start_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic make_random(input int n);
        stream = {};
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
    endtask

    initial begin
        int base;
        #12;
        check_reset_outputs("reset");
        #8 rst = 1'b0;

        // Two-word program
        stream = {8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        run_load(0);
        check("prog_word0", imem_model[0], 32'h0000_0513);
        check("prog_word1", imem_model[1], 32'h0010_0593);

        // Same program with a stalling source
        pulse_start();
        run_load(40);

        // Stream bytes in DONE are not taken
        base = we_count;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            check("done_ignores_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("done_ignores_writes", 32'(we_count - base), 32'd0);
        check("done_holds", {31'd0, done}, 32'd1);

        // Illegal lengths
        pulse_start();
        stream = {8'h00, 8'h00};
        run_load(20);
        pulse_start();
        stream = {8'h01, 8'h01};
        run_load(20);
        pulse_start();
        make_random(3);
        run_load(25);

        // Restart from DONE
        pulse_start();
        stream = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(0);
        check("deadbeef", imem_model[0], 32'hDEAD_BEEF);

        // Reset after one word plus two bytes
        pulse_start();
        base     = we_count;
        stream   = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_addr.push_back(0);
        exp_data.push_back(32'h4433_2211);
        for (int i = 0; i < stream.size(); i++) send_byte(stream[i], 30);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midload");
        repeat (4) @(posedge clk);
        #1;
        check("midload_writes", 32'(we_count - base), 32'd1);
        check("midload_pending", 32'(exp_addr.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        make_random(int'($urandom_range(1, 6)));
        run_load(30);

        // Random loads of assorted sizes
        for (int k = 0; k < 3; k++) begin
            pulse_start();
            make_random(int'($urandom_range(1, 8)));
            run_load(int'($urandom_range(0, 50)));
        end

        // Largest legal program with incrementing words
        pulse_start();
        stream = {8'h00, 8'h01};
        for (int i = 0; i < 256; i++) begin
            stream.push_back(8'(i));
            stream.push_back(8'(i >> 8));
            stream.push_back(8'h00);
            stream.push_back(8'hA5);
        end
        run_load(15);
        check("max_last_addr", {24'd0, imem_addr}, 32'd255);
        check("max_last_word", imem_model[255], 32'hA500_00FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
